bus_dma_master: RTL

BUS_DMA_MASTER -- requirements
Module: bus_dma_master

---
 rtl/bus_dma_master_if.sv | 35 +++
 rtl/bus_dma_master.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bus_dma_master_if.sv
// Bus-side signal bundle for bus_dma_master.
// The master modport is used by the DMA engine; the slave modport is the
// arbiter/memory side.
//   m_req   : bus request (master -> slave)
//   m_wr    : 1 = write, 0 = read (master -> slave)
//   m_addr  : 16-bit word address (master -> slave)
//   m_dout  : 64-bit write data (master -> slave)
//   m_grant : bus grant from the arbiter (slave -> master)
//   m_din   : 64-bit read data (slave -> master)
interface bus_dma_master_if;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;

  modport master (
    output m_req,
    output m_wr,
    output m_addr,
    output m_dout,
    input  m_grant,
    input  m_din
  );

  modport slave (
    input  m_req,
    input  m_wr,
    input  m_addr,
    input  m_dout,
    output m_grant,
    output m_din
  );
endinterface

// File: rtl/bus_dma_master.sv
// Word-by-word memory copy engine. Each word is read from src+cnt and
// written to dst+cnt over a single shared bus, holding the request for the
// whole copy. Losing the grant mid-word restarts that word.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : one-cycle pulse, honoured only in IDLE
//   src_addr : first source word address
//   dst_addr : first destination word address
//   len      : number of 64-bit words (0..255)
//   busy     : high from the cycle after an accepted start through the done cycle
//   done     : one-cycle completion pulse
//   bus      : master side of bus_dma_master_if
//
// state | meaning
// IDLE  | waiting for start, all outputs 0
// REQ   | requesting the bus, waiting for grant
// RD    | read address phase for word cnt
// RWAIT | read data returns; captured at the end of this cycle
// WR    | write buffered word to dst+cnt, then advance
// DONE  | one-cycle completion pulse
module bus_dma_master (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             src_addr,
  input  logic [15:0]             dst_addr,
  input  logic [7:0]              len,
  output logic                    busy,
  output logic                    done,
  bus_dma_master_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RD    = 3'd2,
    S_RWAIT = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt;
  logic [63:0] buf_q;

  // 9-bit so the compare stays correct when cnt reaches 255
  logic [8:0]  cnt_inc;
  logic        last_word;

  assign cnt_inc   = {1'b0, cnt} + 9'd1;
  assign last_word = (cnt_inc >= {1'b0, len_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (len == 8'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.m_grant) state_next = S_RD;
      end
      S_RD: begin
        state_next = bus.m_grant ? S_RWAIT : S_REQ;
      end
      S_RWAIT: begin
        state_next = bus.m_grant ? S_WR : S_REQ;
      end
      S_WR: begin
        if (!bus.m_grant) state_next = S_REQ;
        else if (last_word) state_next = S_DONE;
        else state_next = S_RD;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture and increment only happen on granted cycles, so an
  // aborted word leaves cnt and the buffer untouched for the retry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      cnt   <= '0;
      buf_q <= '0;
    end else begin
      if (state == S_IDLE && start && len != 8'd0) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len;
        cnt   <= '0;
      end
      if (state == S_RWAIT && bus.m_grant) begin
        buf_q <= bus.m_din;
      end
      if (state == S_WR && bus.m_grant) begin
        cnt <= cnt_inc[7:0];
      end
    end
  end

  logic        req_o;
  logic        wr_o;
  logic [15:0] addr_o;
  logic [63:0] dout_o;
  logic        busy_o;
  logic        done_o;

  always_comb begin
    req_o  = 1'b0;
    wr_o   = 1'b0;
    addr_o = '0;
    dout_o = '0;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state)
      S_REQ: begin
        req_o  = 1'b1;
        busy_o = 1'b1;
      end
      S_RD, S_RWAIT: begin
        req_o  = 1'b1;
        busy_o = 1'b1;
        addr_o = src_q + {8'h00, cnt};
      end
      S_WR: begin
        req_o  = 1'b1;
        wr_o   = 1'b1;
        busy_o = 1'b1;
        addr_o = dst_q + {8'h00, cnt};
        dout_o = buf_q;
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.m_req  = req_o;
  assign bus.m_wr   = wr_o;
  assign bus.m_addr = addr_o;
  assign bus.m_dout = dout_o;
  assign busy       = busy_o;
  assign done       = done_o;

endmodule
